// File: rtl/alu_retry_sequencer_pkg.sv
// rtl/alu_retry_sequencer_pkg.sv - shared opcodes, FSM states and status codes
// Purpose: constants and helpers shared by the retry sequencer and its tests.
// Contents: ALU opcode constants, sequencer state enum, response status codes,
//           and the opcode-to-checker selection function.
package alu_retry_sequencer_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_EVAL,
    S_RESP
  } state_t;

  localparam logic [1:0] STATUS_CLEAN     = 2'd0;
  localparam logic [1:0] STATUS_RECOVERED = 2'd1;
  localparam logic [1:0] STATUS_UNRECOV   = 2'd2;

  // One-hot mask in err_sticky bit order {sll, sra, add} naming the checker
  // that guards this opcode; all-zero when no checker applies.
  function automatic logic [2:0] err_select(input logic [4:0] opcode);
    case (opcode)
      OP_ADD, OP_SUB: return 3'b001;
      OP_SRA:         return 3'b010;
      OP_SLL:         return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts inc pulses, sticks at all-ones; clr wins over inc.
// Ports: clock, reset (async active-high), inc, clr, count[W-1:0].
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_retry_sequencer.sv
// rtl/alu_retry_sequencer.sv - issues one ALU op, retries on checker error
// Purpose: accepts an ALU request, drives the external fault-checked ALU from
//          registered operands, re-executes on a relevant checker error up to
//          MAX_RETRY times, returns a tagged response, keeps error statistics.
// Ports: req_* request handshake and payload; inj_* fault-injection controls;
//        alu_* drive to / sample from the ALU; resp_* response handshake and
//        payload; clr_stats, stat_errors, stat_unrecov, err_sticky statistics.
module alu_retry_sequencer
  import alu_retry_sequencer_pkg::*;
#(
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_opcode,
  input  logic [4:0]       req_shamt,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic             inj_flip1,
  input  logic             inj_flip2,
  input  logic             inj_transient,
  output logic [4:0]       alu_opcode,
  output logic [4:0]       alu_shiftamt,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic             alu_flip1,
  output logic             alu_flip2,
  input  logic [31:0]      alu_result,
  input  logic             alu_ne,
  input  logic             alu_lt,
  input  logic             alu_add_err,
  input  logic             alu_sra_err,
  input  logic             alu_sll_err,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic             resp_ne,
  output logic             resp_lt,
  output logic [1:0]       resp_status,
  output logic [2:0]       resp_attempts,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] stat_errors,
  output logic [CNT_W-1:0] stat_unrecov,
  output logic [2:0]       err_sticky
);

  state_t      state, state_next;
  logic [2:0]  attempt;
  logic        lat_flip1, lat_flip2, lat_transient;
  logic [31:0] smp_result;
  logic        smp_ne, smp_lt;
  logic [2:0]  smp_err;        // {sll, sra, add} captured at end of EXEC

  logic        accept, retry, finish, give_up, err_now;
  logic [1:0]  fin_status;
  logic [2:0]  sticky_set;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    retry      = 1'b0;
    finish     = 1'b0;
    give_up    = 1'b0;
    err_now    = 1'b0;
    fin_status = STATUS_CLEAN;
    sticky_set = 3'b000;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = S_EXEC;
        end
      end
      S_EXEC: state_next = S_EVAL;
      S_EVAL: begin
        // Only the checker guarding this opcode counts; others are ignored.
        sticky_set = err_select(alu_opcode) & smp_err;
        err_now    = |sticky_set;
        if (err_now && (attempt < 3'(MAX_RETRY))) begin
          retry      = 1'b1;
          state_next = S_EXEC;
        end else begin
          finish     = 1'b1;
          state_next = S_RESP;
          if (err_now) begin
            give_up    = 1'b1;
            fin_status = STATUS_UNRECOV;
          end else if (attempt != 3'd0) begin
            fin_status = STATUS_RECOVERED;
          end
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The latched operands live directly in the alu_* output registers, so the
  // ALU sees stable operands from the first EXEC cycle through every retry.
  // Flips are only non-zero while in EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alu_opcode    <= '0;
      alu_shiftamt  <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_flip1     <= 1'b0;
      alu_flip2     <= 1'b0;
      lat_flip1     <= 1'b0;
      lat_flip2     <= 1'b0;
      lat_transient <= 1'b0;
      attempt       <= '0;
      smp_result    <= '0;
      smp_ne        <= 1'b0;
      smp_lt        <= 1'b0;
      smp_err       <= '0;
      resp_result   <= '0;
      resp_ne       <= 1'b0;
      resp_lt       <= 1'b0;
      resp_status   <= STATUS_CLEAN;
      resp_attempts <= '0;
    end else begin
      if (accept) begin
        alu_opcode    <= req_opcode;
        alu_shiftamt  <= req_shamt;
        alu_a         <= req_a;
        alu_b         <= req_b;
        alu_flip1     <= inj_flip1;
        alu_flip2     <= inj_flip2;
        lat_flip1     <= inj_flip1;
        lat_flip2     <= inj_flip2;
        lat_transient <= inj_transient;
        attempt       <= '0;
      end
      if (state == S_EXEC) begin
        smp_result <= alu_result;
        smp_ne     <= alu_ne;
        smp_lt     <= alu_lt;
        smp_err    <= {alu_sll_err, alu_sra_err, alu_add_err};
        alu_flip1  <= 1'b0;
        alu_flip2  <= 1'b0;
      end
      if (retry) begin
        attempt   <= attempt + 3'd1;
        // Retries are never attempt 0, so a transient fault is not replayed.
        alu_flip1 <= lat_flip1 & ~lat_transient;
        alu_flip2 <= lat_flip2 & ~lat_transient;
      end
      if (finish) begin
        resp_result   <= smp_result;
        resp_ne       <= smp_ne;
        resp_lt       <= smp_lt;
        resp_status   <= fin_status;
        resp_attempts <= attempt;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_sticky <= '0;
    end else if (clr_stats) begin
      err_sticky <= '0;
    end else begin
      err_sticky <= err_sticky | sticky_set;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (err_now),
    .clr   (clr_stats),
    .count (stat_errors)
  );

  sat_counter #(.W(CNT_W)) u_unrecov_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (give_up),
    .clr   (clr_stats),
    .count (stat_unrecov)
  );

endmodule

// File: tb/tb_alu_retry_sequencer.sv
// tb/tb_alu_retry_sequencer.sv - randomized self-checking bench for alu_retry_sequencer
module tb_alu_retry_sequencer;

  localparam int MAXR  = 3;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_opcode = '0;
  logic [4:0]    req_shamt = '0;
  logic [31:0]   req_a = '0;
  logic [31:0]   req_b = '0;
  logic          inj_flip1 = 1'b0;
  logic          inj_flip2 = 1'b0;
  logic          inj_transient = 1'b0;
  logic [4:0]    alu_opcode;
  logic [4:0]    alu_shiftamt;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic          alu_flip1;
  logic          alu_flip2;
  logic [31:0]   alu_result;
  logic          alu_ne;
  logic          alu_lt;
  logic          alu_add_err;
  logic          alu_sra_err;
  logic          alu_sll_err;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_result;
  logic          resp_ne;
  logic          resp_lt;
  logic [1:0]    resp_status;
  logic [2:0]    resp_attempts;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] stat_errors;
  logic [CW-1:0] stat_unrecov;
  logic [2:0]    err_sticky;

  // Environment fault knobs for the behavioural ALU
  logic force_add = 1'b0;
  logic force_sll = 1'b0;
  logic force_sra = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int m_err = 0;
  int m_unrec = 0;
  logic [2:0] m_sticky = 3'b000;

  always #5 clock = ~clock;

  alu_retry_sequencer #(.MAX_RETRY(MAXR), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
    .inj_flip1(inj_flip1), .inj_flip2(inj_flip2), .inj_transient(inj_transient),
    .alu_opcode(alu_opcode), .alu_shiftamt(alu_shiftamt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_flip1(alu_flip1), .alu_flip2(alu_flip2),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt),
    .alu_add_err(alu_add_err), .alu_sra_err(alu_sra_err), .alu_sll_err(alu_sll_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_ne(resp_ne), .resp_lt(resp_lt),
    .resp_status(resp_status), .resp_attempts(resp_attempts),
    .clr_stats(clr_stats), .stat_errors(stat_errors), .stat_unrecov(stat_unrecov),
    .err_sticky(err_sticky)
  );

  function automatic logic [31:0] base_op(input logic [4:0] opc, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
    case (opc)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return $unsigned($signed(a) >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural fault-checked ALU: flips corrupt the adder output bits 0/1 and
  // raise the adder checker whatever the opcode.
  always_comb begin
    alu_result = base_op(alu_opcode, alu_shiftamt, alu_a, alu_b);
    if (alu_opcode <= 5'd1) alu_result = alu_result ^ {30'd0, alu_flip2, alu_flip1};
    alu_ne      = (alu_a != alu_b);
    alu_lt      = ($signed(alu_a) < $signed(alu_b));
    alu_add_err = alu_flip1 | alu_flip2 | force_add;
    alu_sll_err = force_sll;
    alu_sra_err = force_sra;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_status", 32'(resp_status), 32'd0);
    check("rst_resp_attempts", 32'(resp_attempts), 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    check("rst_resp_ne_lt", 32'({resp_ne, resp_lt}), 32'd0);
    check("rst_alu_ops", 32'({alu_opcode, alu_shiftamt}), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_flips", 32'({alu_flip1, alu_flip2}), 32'd0);
    check("rst_stat_errors", 32'(stat_errors), 32'd0);
    check("rst_stat_unrecov", 32'(stat_unrecov), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
  endtask

  // One full request/response transaction plus the reference model.
  // hold: cycles resp_ready stays low after resp_valid (0 = ready from issue);
  // clr_at: cycle (1..3) at whose closing edge clr_stats is high, 0 = none.
  task automatic run_op(input logic [4:0] opc, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic f1, input logic f2, input logic tr,
                        input logic fadd, input logic fsll, input logic fsra,
                        input int hold, input int clr_at);
    logic rel [0:7];
    int att;
    int cyc;
    logic unrec;
    logic act;
    logic [1:0] exp_status;
    logic [31:0] exp_res;
    logic [31:0] held;

    // Reference model: per-attempt relevance of a checker error.
    for (int k = 0; k <= MAXR; k++) begin
      act = !tr || (k == 0);
      rel[k] = ((opc <= 5'd1) && ((act && (f1 || f2)) || fadd)) ||
               ((opc == 5'd4) && fsll) || ((opc == 5'd5) && fsra);
    end
    att = 0;
    while (att < MAXR && rel[att]) att++;
    unrec = rel[att];
    exp_status = unrec ? 2'd2 : (att > 0 ? 2'd1 : 2'd0);
    exp_res = base_op(opc, sh, a, b);
    if (opc <= 5'd1 && (!tr || att == 0)) exp_res = exp_res ^ {30'd0, f2, f1};
    if (clr_at > 0) begin
      m_err = 0; m_unrec = 0; m_sticky = 3'b000;
    end
    for (int k = 0; k <= att; k++) begin
      if (rel[k] && (clr_at == 0 || 2 + 2 * k > clr_at)) begin
        if (m_err < SAT) m_err++;
        if (opc <= 5'd1) m_sticky[0] = 1'b1;
        if (opc == 5'd5) m_sticky[1] = 1'b1;
        if (opc == 5'd4) m_sticky[2] = 1'b1;
      end
    end
    if (unrec && (clr_at == 0 || 2 + 2 * att > clr_at) && m_unrec < SAT) m_unrec++;

    @(negedge clock);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    force_add = fadd; force_sll = fsll; force_sra = fsra;
    req_opcode = opc; req_shamt = sh; req_a = a; req_b = b;
    inj_flip1 = f1; inj_flip2 = f2; inj_transient = tr;
    req_valid = 1'b1;
    resp_ready = (hold == 0);
    @(posedge clock);
    #1 req_valid = 1'b0;

    cyc = 1;
    while (cyc < 40) begin
      @(negedge clock);
      clr_stats = (cyc == clr_at);
      if (resp_valid) break;
      if (cyc == 1) check("busy_req_ready", 32'(req_ready), 32'd0);
      cyc++;
    end
    check("resp_cycle", 32'(cyc), 32'(3 + 2 * att));
    check("resp_result", resp_result, exp_res);
    check("resp_status", 32'(resp_status), 32'(exp_status));
    check("resp_attempts", 32'(resp_attempts), 32'(att));
    check("resp_ne", 32'(resp_ne), 32'(a != b));
    check("resp_lt", 32'(resp_lt), 32'($signed(a) < $signed(b)));
    held = resp_result;

    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      clr_stats = 1'b0;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_result", resp_result, held);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    clr_stats = 1'b0;
    resp_ready = 1'($urandom_range(0, 1));
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
    check("post_result_held", resp_result, held);
    check("post_status_held", 32'(resp_status), 32'(exp_status));
    check("stat_errors", 32'(stat_errors), 32'(m_err));
    check("stat_unrecov", 32'(stat_unrecov), 32'(m_unrec));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    force_add = 1'b0; force_sll = 1'b0; force_sra = 1'b0;
  endtask

  task automatic reset_mid_op();
    @(negedge clock);
    req_opcode = 5'd1; req_shamt = 5'd0; req_a = 32'd20; req_b = 32'd4;
    inj_flip1 = 1'b0; inj_flip2 = 1'b1; inj_transient = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    check("retry_exec_flip2", 32'(alu_flip2), 32'd1);
    check("retry_exec_busy", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clock);
    reset = 1'b0;
    inj_flip2 = 1'b0;
    m_err = 0; m_unrec = 0; m_sticky = 3'b000;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b0;

    run_op(5'd0, 5'd0, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    run_op(5'd1, 5'd0, 32'd3, 32'd9, 1, 0, 1, 0, 0, 0, 0, 0);
    run_op(5'd1, 5'd0, 32'd3, 32'd9, 0, 1, 0, 0, 0, 0, 0, 0);
    run_op(5'd2, 5'd0, 32'hF0F0, 32'h0FF0, 1, 0, 0, 1, 0, 0, 0, 0);
    run_op(5'd3, 5'd0, 32'h1234, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 5, 0);
    run_op(5'd4, 5'd3, 32'h0000_0011, 32'd0, 0, 0, 0, 0, 1, 0, 1, 0);
    run_op(5'd5, 5'd4, 32'h8000_0100, 32'd0, 0, 0, 0, 0, 0, 1, 0, 0);
    run_op(5'd1, 5'd0, 32'd50, 32'd8, 0, 1, 0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++)
      run_op(5'd0, 5'd0, 32'd100, 32'(i), 1, 1, 0, 0, 0, 0, 0, 0);
    run_op(5'd0, 5'd0, 32'd1, 32'd2, 1, 0, 0, 0, 0, 0, 0, 2);

    reset_mid_op();
    run_op(5'd0, 5'd0, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(5'($urandom_range(0, 7)), 5'($urandom), $urandom, $urandom,
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             $urandom_range(0, 3),
             ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_retry_sequencer.md
# alu_retry_sequencer

Sequencer that sits between an instruction issuer and the fault-checked ALU (adder, SLL and SRA checkers). It accepts one ALU operation at a time over a valid/ready handshake and drives the ALU from registered operands. It samples the checker flag that matches the opcode and re-executes the operation up to `MAX_RETRY` times on error. It then returns the result tagged clean, recovered or unrecoverable, keeps saturating error statistics, and drives the adder fault-injection controls for transient or permanent fault campaigns.

## Interface
- `MAX_RETRY`, 3, retries allowed after the first attempt (1..7)
- `CNT_W`, 16, width of statistics counters
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `req_valid` / `req_ready` in/out 1: request handshake; `req_ready` is high only in IDLE
- `req_opcode` in 5, `req_shamt` in 5, `req_a` / `req_b` in 32: operation payload
- `inj_flip1` / `inj_flip2` in 1: requested adder fault injection, captured with the request
- `inj_transient` in 1: 1 = inject on attempt 0 only; 0 = inject on every attempt
- `alu_opcode` out 5, `alu_shiftamt` out 5, `alu_a` / `alu_b` out 32, `alu_flip1` / `alu_flip2` out 1: registered ALU drive
- `alu_result` in 32, `alu_ne` / `alu_lt` in 1, `alu_add_err` / `alu_sra_err` / `alu_sll_err` in 1: ALU outputs
- `resp_valid` out 1, `resp_ready` in 1: response handshake
- `resp_result` out 32, `resp_ne` / `resp_lt` out 1: captured ALU outputs
- `resp_status` out 2: 0 clean, 1 recovered, 2 unrecoverable
- `resp_attempts` out 3: attempts used, minus 1
- `clr_stats` in 1: synchronous clear of the statistics below
- `stat_errors` out CNT_W: saturating count of checker errors seen
- `stat_unrecov` out CNT_W: saturating count of unrecoverable operations
- `err_sticky` out 3: sticky flags, bits {sll, sra, add}

## Operation
- The FSM has four states: IDLE, EXEC, EVAL and RESP.
- IDLE: when `req_valid`, latch the payload and injection bits, clear the attempt counter, and go to EXEC.
- EXEC: drive the latched operands onto `alu_*`. Drive the flips when `inj_transient`=0 or attempt=0; otherwise drive them 0. At the end of the cycle, register `alu_result`, `alu_ne`, `alu_lt` and the checker flags.
- EVAL: the relevant error depends on the opcode:
  - opcodes 0 and 1 use `alu_add_err`;
  - opcode 4 uses `alu_sll_err`;
  - opcode 5 uses `alu_sra_err`;
  - any other opcode has no relevant error (always 0).
- EVAL transitions:
  - relevant error and attempt < MAX_RETRY: attempt++, go to EXEC;
  - relevant error and attempt = MAX_RETRY: status 2, go to RESP;
  - no relevant error: status is 1 if attempt > 0, else 0; go to RESP.
- EVAL, each relevant error: `stat_errors` +1, saturating at all-ones, and the matching `err_sticky` bit is set. Irrelevant checker flags are ignored and not counted.
- Entering RESP with status 2: `stat_unrecov` +1, saturating.
- RESP: hold `resp_valid`=1 with the payload stable until `resp_ready`, then return to IDLE. `resp_ready` may be high before `resp_valid`.
- `clr_stats` zeroes the counters and sticky flags and takes priority over an increment in the same cycle.
- `resp_*` holds the last response after the handshake; only `resp_valid` drops.

## Timing
- Handshake at cycle 0 gives EXEC at cycle 1 and EVAL at cycle 2. `resp_valid` rises at cycle 3 with no error. Each retry adds 2 cycles.
- With `resp_ready` held high, the next `req_ready` is at cycle 4. There is no back-to-back issue.
- Reset values:
  - state IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_status`=0, `resp_attempts`=0;
  - all `alu_*` outputs 0, `resp_result`, `resp_ne` and `resp_lt` 0;
  - statistics 0, `err_sticky`=0.
- A reset mid-operation aborts it with no response and no count.
- Requests presented outside IDLE are not accepted and must be held by the issuer.

## Structure
- A shared package holds:
  - opcode constants (ADD 0, SUB 1, AND 2, OR 3, SLL 4, SRA 5);
  - the state enum;
  - status codes.
- One sub-module, `sat_counter`, parameterised by width with inc/clr inputs, is instantiated twice.
- The ALU is instantiated outside this block; this block only drives and samples it.

## Test plan
- ADD, A=5, B=7, no injection → `resp_result`=12, status 0, attempts 0, `resp_valid` at cycle 3.
- SUB, A=3, B=9, `inj_flip1`=1, `inj_transient`=1 → status 1, attempts 1, result 0xFFFFFFFA, `stat_errors`=1, `err_sticky`=001.
- SUB with `inj_flip2`=1, `inj_transient`=0, MAX_RETRY=3 → status 2, attempts 3, `stat_errors`=4, `stat_unrecov`=1, `resp_valid` at cycle 9.
- AND with `inj_flip1`=1 and a forced `alu_add_err`=1 → status 0, no count, since the error is irrelevant to the opcode.
- Hold `resp_ready`=0 for 5 cycles → `resp_valid` and payload stable, `req_ready`=0 throughout, a single response on release.
- Assert `reset` during EXEC of a retry → all outputs return to reset values immediately, then a following ADD completes normally. Preload counters to all-ones → saturate, and `clr_stats` coincident with an error → 0.
